// File: rtl/cluster_bus_ar_arbiter.sv
// Round-robin AR arbiter with per-requester outstanding limits and ID-prefix R routing.
// Optional grant statistics are enabled by defining CLUSTER_BUS_AR_ARB_STATS_EN.
module cluster_bus_ar_arbiter #(
  parameter int NB_REQ       = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int ID_IN_WIDTH  = 4,
  parameter int ID_OUT_WIDTH = ID_IN_WIDTH + $clog2(NB_REQ),
  parameter int MAX_OUTSTND  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NB_REQ-1:0]            req_ar_valid_i,
  output logic [NB_REQ-1:0]            req_ar_ready_o,
  input  logic [NB_REQ*ADDR_WIDTH-1:0] req_ar_addr_i,
  input  logic [NB_REQ*ID_IN_WIDTH-1:0] req_ar_id_i,
  input  logic [NB_REQ*8-1:0]          req_ar_len_i,
  output logic                         mst_ar_valid_o,
  input  logic                         mst_ar_ready_i,
  output logic [ADDR_WIDTH-1:0]        mst_ar_addr_o,
  output logic [ID_OUT_WIDTH-1:0]      mst_ar_id_o,
  output logic [7:0]                   mst_ar_len_o,
  input  logic                         mst_r_valid_i,
  output logic                         mst_r_ready_o,
  input  logic [ID_OUT_WIDTH-1:0]      mst_r_id_i,
  input  logic [DATA_WIDTH-1:0]        mst_r_data_i,
  input  logic [1:0]                   mst_r_resp_i,
  input  logic                         mst_r_last_i,
  output logic [NB_REQ-1:0]            req_r_valid_o,
  input  logic [NB_REQ-1:0]            req_r_ready_i,
  output logic [ID_IN_WIDTH-1:0]       req_r_id_o,
  output logic [DATA_WIDTH-1:0]        req_r_data_o,
  output logic [1:0]                   req_r_resp_o,
  output logic                         req_r_last_o,
  output logic                         err_o
`ifdef CLUSTER_BUS_AR_ARB_STATS_EN
  ,
  output logic [NB_REQ*16-1:0]         grant_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NB_REQ);
  localparam int PFX_W = ID_OUT_WIDTH - ID_IN_WIDTH;
  localparam int CNT_W = $clog2(MAX_OUTSTND + 1);

  generate
    if (ID_OUT_WIDTH < ID_IN_WIDTH + $clog2(NB_REQ)) begin : g_id_width_check
      $error("ID_OUT_WIDTH too small to hold the requester prefix");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_next;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       winner, win_hi, win_lo;
  logic                   found_hi, found_lo;
  logic                   grant_valid, grant_fire;
  logic [NB_REQ-1:0]      eligible;
  logic [CNT_W-1:0]       cnt [NB_REQ];
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [ID_IN_WIDTH-1:0] sel_id;
  logic [7:0]             sel_len;
  logic [PFX_W-1:0]       r_idx;
  logic                   r_in_range, r_last_fire, underflow;
  logic [NB_REQ-1:0]      inc_vec, dec_vec;

  always_comb begin
    eligible = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      eligible[k] = req_ar_valid_i[k] && (cnt[k] < CNT_W'(MAX_OUTSTND));
    end
  end

  // Round-robin search split in two passes: from ptr upward, then wrapping from 0.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      if (!found_hi && eligible[k] && (IDX_W'(k) >= ptr)) begin
        found_hi = 1'b1;
        win_hi   = IDX_W'(k);
      end
      if (!found_lo && eligible[k]) begin
        found_lo = 1'b1;
        win_lo   = IDX_W'(k);
      end
    end
    grant_valid = found_hi || found_lo;
    winner      = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    sel_addr = '0;
    sel_id   = '0;
    sel_len  = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      if (winner == IDX_W'(k)) begin
        sel_addr = req_ar_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_id   = req_ar_id_i[k*ID_IN_WIDTH +: ID_IN_WIDTH];
        sel_len  = req_ar_len_i[k*8 +: 8];
      end
    end
  end

  always_comb begin
    state_next     = state;
    req_ar_ready_o = '0;
    grant_fire     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          grant_fire = 1'b1;
          state_next = BUSY;
          for (int k = 0; k < NB_REQ; k++) begin
            req_ar_ready_o[k] = (winner == IDX_W'(k));
          end
        end
      end
      BUSY: begin
        if (mst_ar_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Beats whose prefix names no requester are accepted and discarded.
  always_comb begin
    r_idx         = mst_r_id_i[ID_OUT_WIDTH-1:ID_IN_WIDTH];
    r_in_range    = 1'b0;
    req_r_valid_o = '0;
    mst_r_ready_o = 1'b1;
    for (int k = 0; k < NB_REQ; k++) begin
      if (r_idx == PFX_W'(k)) begin
        r_in_range       = 1'b1;
        req_r_valid_o[k] = mst_r_valid_i;
        mst_r_ready_o    = req_r_ready_i[k];
      end
    end
    r_last_fire = mst_r_valid_i && mst_r_ready_o && mst_r_last_i;
  end

  assign req_r_id_o   = mst_r_id_i[ID_IN_WIDTH-1:0];
  assign req_r_data_o = mst_r_data_i;
  assign req_r_resp_o = mst_r_resp_i;
  assign req_r_last_o = mst_r_last_i;

  always_comb begin
    inc_vec   = '0;
    dec_vec   = '0;
    underflow = 1'b0;
    for (int k = 0; k < NB_REQ; k++) begin
      inc_vec[k] = grant_fire && (winner == IDX_W'(k));
      dec_vec[k] = r_last_fire && r_in_range && (r_idx == PFX_W'(k));
      if (dec_vec[k] && (cnt[k] == '0)) begin
        underflow = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      ptr            <= '0;
      mst_ar_valid_o <= 1'b0;
      mst_ar_addr_o  <= '0;
      mst_ar_id_o    <= '0;
      mst_ar_len_o   <= '0;
      err_o          <= 1'b0;
      for (int k = 0; k < NB_REQ; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      state <= state_next;
      if (grant_fire) begin
        mst_ar_valid_o <= 1'b1;
        mst_ar_addr_o  <= sel_addr;
        mst_ar_id_o    <= {PFX_W'(winner), sel_id};
        mst_ar_len_o   <= sel_len;
        ptr            <= (winner == IDX_W'(NB_REQ - 1)) ? '0 : winner + 1'b1;
      end else if ((state == BUSY) && mst_ar_ready_i) begin
        mst_ar_valid_o <= 1'b0;
      end
      for (int k = 0; k < NB_REQ; k++) begin
        if (inc_vec[k] && !dec_vec[k]) begin
          cnt[k] <= cnt[k] + 1'b1;
        end else if (dec_vec[k] && !inc_vec[k] && (cnt[k] != '0)) begin
          cnt[k] <= cnt[k] - 1'b1;
        end
      end
      if ((mst_r_valid_i && !r_in_range) || underflow) begin
        err_o <= 1'b1;
      end
    end
  end

`ifdef CLUSTER_BUS_AR_ARB_STATS_EN
  logic [15:0] grant_cnt [NB_REQ];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NB_REQ; k++) begin
        grant_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NB_REQ; k++) begin
        if (inc_vec[k] && (grant_cnt[k] != 16'hFFFF)) begin
          grant_cnt[k] <= grant_cnt[k] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NB_REQ; g++) begin : g_stats
    assign grant_cnt_o[g*16 +: 16] = grant_cnt[g];
  end
`endif

endmodule

// File: tb/tb_cluster_bus_ar_arbiter.sv
// Scoreboard bench for cluster_bus_ar_arbiter: directed stimulus pushes expected
// AR/R responses, a negedge monitor pops and compares on every handshake/beat.
module tb_cluster_bus_ar_arbiter;
  localparam int NB_REQ = 4;
  localparam int AW     = 32;
  localparam int DW     = 64;
  localparam int IDI    = 4;
  localparam int IDO    = 6;
  localparam int MAXO   = 2;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic [NB_REQ-1:0]     req_ar_valid_i;
  logic [NB_REQ-1:0]     req_ar_ready_o;
  logic [NB_REQ*AW-1:0]  req_ar_addr_i;
  logic [NB_REQ*IDI-1:0] req_ar_id_i;
  logic [NB_REQ*8-1:0]   req_ar_len_i;
  logic                  mst_ar_valid_o;
  logic                  mst_ar_ready_i;
  logic [AW-1:0]         mst_ar_addr_o;
  logic [IDO-1:0]        mst_ar_id_o;
  logic [7:0]            mst_ar_len_o;
  logic                  mst_r_valid_i;
  logic                  mst_r_ready_o;
  logic [IDO-1:0]        mst_r_id_i;
  logic [DW-1:0]         mst_r_data_i;
  logic [1:0]            mst_r_resp_i;
  logic                  mst_r_last_i;
  logic [NB_REQ-1:0]     req_r_valid_o;
  logic [NB_REQ-1:0]     req_r_ready_i;
  logic [IDI-1:0]        req_r_id_o;
  logic [DW-1:0]         req_r_data_o;
  logic [1:0]            req_r_resp_o;
  logic                  req_r_last_o;
  logic                  err_o;

  cluster_bus_ar_arbiter #(
    .NB_REQ(NB_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ID_IN_WIDTH(IDI), .ID_OUT_WIDTH(IDO), .MAX_OUTSTND(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_ar_valid_i(req_ar_valid_i), .req_ar_ready_o(req_ar_ready_o),
    .req_ar_addr_i(req_ar_addr_i), .req_ar_id_i(req_ar_id_i), .req_ar_len_i(req_ar_len_i),
    .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
    .mst_ar_addr_o(mst_ar_addr_o), .mst_ar_id_o(mst_ar_id_o), .mst_ar_len_o(mst_ar_len_o),
    .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o), .mst_r_id_i(mst_r_id_i),
    .mst_r_data_i(mst_r_data_i), .mst_r_resp_i(mst_r_resp_i), .mst_r_last_i(mst_r_last_i),
    .req_r_valid_o(req_r_valid_o), .req_r_ready_i(req_r_ready_i), .req_r_id_o(req_r_id_o),
    .req_r_data_o(req_r_data_o), .req_r_resp_o(req_r_resp_o), .req_r_last_o(req_r_last_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [IDO-1:0] id;
    logic [7:0]     len;
  } ar_exp_t;

  typedef struct {
    logic [NB_REQ-1:0] valid;
    logic [IDI-1:0]    id;
    logic [DW-1:0]     data;
    logic              ready;
  } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  int      vectors = 0;
  int      miscompares = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic [NB_REQ-1:0] valid);
    req_ar_valid_i = valid;
  endtask

  task automatic setReq(input int k, input logic [AW-1:0] addr, input logic [IDI-1:0] id, input logic [7:0] len);
    req_ar_addr_i[k*AW +: AW]   = addr;
    req_ar_id_i[k*IDI +: IDI]   = id;
    req_ar_len_i[k*8 +: 8]      = len;
  endtask

  task automatic pushAr(input logic [AW-1:0] addr, input logic [IDO-1:0] id, input logic [7:0] len);
    ar_exp_t e;
    e.addr = addr; e.id = id; e.len = len;
    ar_q.push_back(e);
  endtask

  task automatic sendR(input logic [IDO-1:0] id, input logic [DW-1:0] data, input logic last,
                       input logic [NB_REQ-1:0] exp_valid, input logic exp_ready);
    r_exp_t e;
    mst_r_valid_i = 1'b1;
    mst_r_id_i    = id;
    mst_r_data_i  = data;
    mst_r_resp_i  = 2'b00;
    mst_r_last_i  = last;
    e.valid = exp_valid; e.id = id[IDI-1:0]; e.data = data; e.ready = exp_ready;
    r_q.push_back(e);
  endtask

  task automatic clearR();
    mst_r_valid_i = 1'b0;
    mst_r_last_i  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Monitor: every AR handshake and every R beat must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (mst_ar_valid_o && mst_ar_ready_i) begin
        if (ar_q.size() == 0) begin
          checkOutput("unexpected_ar_handshake", 64'(mst_ar_id_o), 64'hFFFF);
        end else begin
          ar_exp_t e;
          e = ar_q.pop_front();
          checkOutput("ar_addr", 64'(mst_ar_addr_o), 64'(e.addr));
          checkOutput("ar_id", 64'(mst_ar_id_o), 64'(e.id));
          checkOutput("ar_len", 64'(mst_ar_len_o), 64'(e.len));
        end
      end
      if (mst_r_valid_i) begin
        if (r_q.size() == 0) begin
          checkOutput("unexpected_r_beat", 64'(mst_r_id_i), 64'hFFFF);
        end else begin
          r_exp_t e;
          e = r_q.pop_front();
          checkOutput("r_valid_route", 64'(req_r_valid_o), 64'(e.valid));
          checkOutput("r_id_stripped", 64'(req_r_id_o), 64'(e.id));
          checkOutput("r_data", req_r_data_o, e.data);
          checkOutput("r_last", 64'(req_r_last_o), 64'(mst_r_last_i));
          checkOutput("mst_r_ready", 64'(mst_r_ready_o), 64'(e.ready));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  int order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    req_ar_valid_i = '0;
    req_ar_addr_i  = '0;
    req_ar_id_i    = '0;
    req_ar_len_i   = '0;
    mst_ar_ready_i = 1'b1;
    mst_r_valid_i  = 1'b0;
    mst_r_id_i     = '0;
    mst_r_data_i   = '0;
    mst_r_resp_i   = 2'b00;
    mst_r_last_i   = 1'b0;
    req_r_ready_i  = 4'hF;
    rst_i          = 1'b1;

    $display("[TB] reset state");
    doReset();
    @(negedge clk);
    checkOutput("rst_ar_valid", 64'(mst_ar_valid_o), 64'h0);
    checkOutput("rst_ar_addr", 64'(mst_ar_addr_o), 64'h0);
    checkOutput("rst_ar_id", 64'(mst_ar_id_o), 64'h0);
    checkOutput("rst_ar_len", 64'(mst_ar_len_o), 64'h0);
    checkOutput("rst_err", 64'(err_o), 64'h0);
    checkOutput("rst_ready", 64'(req_ar_ready_o), 64'h0);
    tick();

    $display("[TB] single request");
    setReq(2, 32'h1000_0040, 4'h3, 8'h00);
    applyStimulus(4'b0100);
    pushAr(32'h1000_0040, 6'h23, 8'h00);
    @(negedge clk);
    checkOutput("single_ready", 64'(req_ar_ready_o), 64'b0100);
    tick();
    applyStimulus(4'b0000);
    @(negedge clk);
    checkOutput("single_ar_valid", 64'(mst_ar_valid_o), 64'h1);
    checkOutput("single_busy_ready", 64'(req_ar_ready_o), 64'h0);
    tick();
    req_r_ready_i = 4'b1011;
    sendR(6'h23, 64'hDEAD_BEEF_0000_0001, 1'b1, 4'b0100, 1'b0);
    @(negedge clk);
    tick();
    req_r_ready_i = 4'hF;
    sendR(6'h23, 64'hDEAD_BEEF_0000_0001, 1'b1, 4'b0100, 1'b1);
    @(negedge clk);
    tick();
    clearR();
    @(negedge clk);
    checkOutput("single_err", 64'(err_o), 64'h0);
    tick();

    $display("[TB] fairness");
    doReset();
    for (int k = 0; k < NB_REQ; k++) setReq(k, 32'h2000_0000 + 32'(k * 256), 4'(k + 4), 8'(k));
    for (int g = 0; g < 6; g++) pushAr(32'h2000_0000 + 32'(order[g] * 256), {2'(order[g]), 4'(order[g] + 4)}, 8'(order[g]));
    mst_ar_ready_i = 1'b1;
    applyStimulus(4'hF);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rr_ready_c%0d", c), 64'(req_ar_ready_o),
                  (c % 2 == 0) ? (64'h1 << order[c / 2]) : 64'h0);
      tick();
    end
    applyStimulus(4'h0);
    @(negedge clk);
    checkOutput("rr_done_valid", 64'(mst_ar_valid_o), 64'h0);
    tick();

    $display("[TB] outstanding limit");
    doReset();
    setReq(0, 32'h3000_0000, 4'h1, 8'h03);
    pushAr(32'h3000_0000, 6'h01, 8'h03);
    pushAr(32'h3000_0000, 6'h01, 8'h03);
    applyStimulus(4'b0001);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput($sformatf("limit_ready_c%0d", c), 64'(req_ar_ready_o), (c == 0 || c == 2) ? 64'h1 : 64'h0);
      tick();
    end
    sendR(6'h01, 64'h0123_4567_89AB_CDEF, 1'b1, 4'b0001, 1'b1);
    @(negedge clk);
    checkOutput("limit_still_full", 64'(req_ar_ready_o), 64'h0);
    tick();
    clearR();
    pushAr(32'h3000_0000, 6'h01, 8'h03);
    @(negedge clk);
    checkOutput("limit_regrant", 64'(req_ar_ready_o), 64'h1);
    tick();
    applyStimulus(4'b0000);
    @(negedge clk);
    tick();

    $display("[TB] master backpressure");
    doReset();
    setReq(3, 32'h4000_00C0, 4'h5, 8'h07);
    mst_ar_ready_i = 1'b0;
    applyStimulus(4'b1000);
    @(negedge clk);
    checkOutput("bp_grant", 64'(req_ar_ready_o), 64'b1000);
    tick();
    applyStimulus(4'b0111);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_valid_c%0d", c), 64'(mst_ar_valid_o), 64'h1);
      checkOutput($sformatf("bp_addr_c%0d", c), 64'(mst_ar_addr_o), 64'h4000_00C0);
      checkOutput($sformatf("bp_id_c%0d", c), 64'(mst_ar_id_o), 64'h35);
      checkOutput($sformatf("bp_len_c%0d", c), 64'(mst_ar_len_o), 64'h07);
      checkOutput($sformatf("bp_ready_c%0d", c), 64'(req_ar_ready_o), 64'h0);
      tick();
    end
    applyStimulus(4'b0000);
    mst_ar_ready_i = 1'b1;
    pushAr(32'h4000_00C0, 6'h35, 8'h07);
    @(negedge clk);
    tick();
    @(negedge clk);
    checkOutput("bp_released", 64'(mst_ar_valid_o), 64'h0);
    tick();

    $display("[TB] simultaneous grant and completion");
    doReset();
    setReq(1, 32'h5000_0000, 4'h2, 8'h01);
    for (int c = 0; c < 6; c += 2) begin
      applyStimulus(4'b0010);
      pushAr(32'h5000_0000, 6'h12, 8'h01);
      if (c == 2) sendR(6'h12, 64'hAAAA_5555_0000_0002, 1'b1, 4'b0010, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("simul_grant_c%0d", c), 64'(req_ar_ready_o), 64'b0010);
      tick();
      applyStimulus(4'b0000);
      clearR();
      @(negedge clk);
      tick();
    end
    applyStimulus(4'b0010);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("simul_blocked_c%0d", c), 64'(req_ar_ready_o), 64'h0);
      tick();
    end
    applyStimulus(4'b0000);
    @(negedge clk);
    checkOutput("simul_err", 64'(err_o), 64'h0);
    tick();

    $display("[TB] error flag and mid-operation reset");
    doReset();
    sendR(6'h10, 64'h0000_0000_0000_0BAD, 1'b1, 4'b0010, 1'b1);
    @(negedge clk);
    checkOutput("err_before", 64'(err_o), 64'h0);
    tick();
    clearR();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("err_sticky_c%0d", c), 64'(err_o), 64'h1);
      tick();
    end
    setReq(2, 32'h6000_0000, 4'h9, 8'h02);
    mst_ar_ready_i = 1'b0;
    applyStimulus(4'b0100);
    @(negedge clk);
    checkOutput("busy_rst_grant", 64'(req_ar_ready_o), 64'b0100);
    tick();
    applyStimulus(4'b0000);
    @(negedge clk);
    checkOutput("busy_rst_pending", 64'(mst_ar_valid_o), 64'h1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    checkOutput("busy_rst_valid", 64'(mst_ar_valid_o), 64'h0);
    checkOutput("busy_rst_err", 64'(err_o), 64'h0);
    checkOutput("busy_rst_addr", 64'(mst_ar_addr_o), 64'h0);
    tick();
    setReq(0, 32'h7000_0000, 4'hA, 8'h00);
    setReq(3, 32'h7000_0300, 4'hB, 8'h00);
    applyStimulus(4'b1001);
    pushAr(32'h7000_0000, 6'h0A, 8'h00);
    @(negedge clk);
    checkOutput("busy_rst_ptr", 64'(req_ar_ready_o), 64'b0001);
    tick();
    applyStimulus(4'b0000);
    mst_ar_ready_i = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);

    checkOutput("ar_queue_drained", 64'(ar_q.size()), 64'h0);
    checkOutput("r_queue_drained", 64'(r_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cluster_bus_ar_arbiter.md
Name: cluster_bus_ar_arbiter

Overview:
- Read-address arbiter and read-response router for the cluster AXI bus.
- Shares one AXI master read port among NB_REQ requesters: core data, instruction refill, DMA and external.
- Arbitration is round-robin with a per-requester outstanding-transaction limit.
- Prefixes the requester index onto the ARID and routes R beats back by that prefix; sits in front of a shared downstream port (ext/periph) of the cluster bus.

Parameters:
- NB_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 32, AR address width
- DATA_WIDTH, 64, R data width
- ID_IN_WIDTH, 4, requester-side ID width
- ID_OUT_WIDTH, ID_IN_WIDTH+$clog2(NB_REQ), master-side ID width; elaboration error if smaller
- MAX_OUTSTND, 8, max in-flight reads per requester (1..255)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_ar_valid_i  in  NB_REQ  per-requester AR valid
- req_ar_ready_o  out  NB_REQ  per-requester AR ready
- req_ar_addr_i  in  NB_REQ*ADDR_WIDTH  AR address, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- req_ar_id_i  in  NB_REQ*ID_IN_WIDTH  ARID
- req_ar_len_i  in  NB_REQ*8  ARLEN
- mst_ar_valid_o  out  1  master AR valid
- mst_ar_ready_i  in  1  master AR ready
- mst_ar_addr_o  out  ADDR_WIDTH  master AR address
- mst_ar_id_o  out  ID_OUT_WIDTH  {requester index, original ID}
- mst_ar_len_o  out  8  master ARLEN
- mst_r_valid_i  in  1  R valid
- mst_r_ready_o  out  1  R ready
- mst_r_id_i  in  ID_OUT_WIDTH  RID
- mst_r_data_i  in  DATA_WIDTH  R data
- mst_r_resp_i  in  2  R resp
- mst_r_last_i  in  1  R last
- req_r_valid_o  out  NB_REQ  per-requester R valid
- req_r_ready_i  in  NB_REQ  per-requester R ready
- req_r_id_o  out  ID_IN_WIDTH  RID with prefix stripped (shared)
- req_r_data_o  out  DATA_WIDTH  shared R data
- req_r_resp_o  out  2  shared R resp
- req_r_last_o  out  1  shared R last
- err_o  out  1  sticky protocol error flag

Behaviour:
- Clock and reset: clk_i only; reset is synchronous, active-high.
- Reset values: mst_ar_valid_o=0; mst_ar_addr_o/id_o/len_o=0; RR pointer=0; all outstanding counters=0; err_o=0; state=IDLE.
- Reset mid-operation: clears all state the next edge, including a pending AR; whole-cluster reset only.
- Eligibility: requester k is eligible when req_ar_valid_i[k] && cnt[k] < MAX_OUTSTND.
- IDLE:
  - Grant the first eligible requester searching from ptr upward, wrapping modulo NB_REQ.
  - req_ar_ready_o[winner]=1 combinationally in that cycle; all other ready bits 0.
  - Next edge: latch addr, len and id={winner,id} into output registers; mst_ar_valid_o=1; cnt[winner]++; ptr=(winner+1)%NB_REQ; state=BUSY.
  - No eligible requester: stay IDLE, all ready bits 0, ptr unchanged.
- BUSY:
  - req_ar_ready_o all 0; outputs held stable.
  - On mst_ar_ready_i=1: mst_ar_valid_o=0 next edge; state=IDLE.
  - Throughput is one AR per 2 cycles minimum; AR latency from requester handshake to mst_ar_valid_o is 1 cycle.
- R path (fully combinational, zero latency):
  - idx=mst_r_id_i[ID_OUT_WIDTH-1:ID_IN_WIDTH].
  - req_r_valid_o[idx]=mst_r_valid_i; other valid bits 0.
  - mst_r_ready_o=req_r_ready_i[idx].
  - data, resp, last and the low ID bits broadcast to all requesters.
- Counter decrement: cnt[idx]-- on mst_r_valid_i && mst_r_ready_o && mst_r_last_i.
- Simultaneous increment and decrement on the same requester: counter unchanged.
- Out-of-range idx (idx>=NB_REQ): mst_r_ready_o=1, beat dropped, err_o set.
- Decrement with cnt[idx]=0: counter stays 0, err_o set.
- err_o clears only on reset.
- A requester at cnt=MAX_OUTSTND is skipped; the RR pointer is not stalled by it.

Optional Feature:
- Macro: CLUSTER_BUS_AR_ARB_STATS_EN.
- Defined: adds output grant_cnt_o [NB_REQ*16]; one 16-bit counter per requester, incremented on each grant, saturating at 16'hFFFF, reset to 0.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Single request: req 2 valid, addr 0x1000_0040, id 3, len 0. Required: ready[2] in cycle 0; mst_ar_valid_o in cycle 1 with id=0x23, addr 0x1000_0040. R beat with id 0x23, last=1 → req_r_valid_o=4'b0100, req_r_id_o=3, cnt[2] returns to 0.
- Fairness: all 4 requesters continuously valid, mst_ar_ready_i=1. Required grant order 0,1,2,3,0,1; one grant every 2 cycles.
- Limit: MAX_OUTSTND=2, requester 0 alone, no R returned. Required: 2 grants, then ready[0] stays 0. One R last with prefix 0 → a third grant follows.
- Master backpressure: mst_ar_ready_i=0 for 5 cycles. Required: addr/id/len stable and valid held; no requester ready asserted.
- Simultaneous: grant to requester 1 and R last for requester 1 on the same edge, cnt[1]=1 before. Required: cnt[1]=1 after.
- Errors: R last with prefix 1 while cnt[1]=0 → err_o=1 next cycle and stays 1. Assert rst_i=1 for one cycle while in BUSY → mst_ar_valid_o=0, err_o=0, ptr=0.
